loop_qual_seq: RTL



---
 rtl/loop_qual_seq_if.sv | 28 ++
 rtl/loop_qual_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/loop_qual_seq_if.sv
// loop_qual_seq_if - control/status bundle of the loop qualifier/sequencer.
//   en, clr_ok           : request and NOR4 fault flag (1 = all comparators clear)
//   loop_en, ss_code     : loop drive enable and soft-start ramp code
//   ss_done, fault       : regulating indication, fault handling in progress
//   lockout, retry_cnt   : retries exhausted, faults since last regulation
// master = controlling side (drives en/clr_ok), slave = the sequencer.
interface loop_qual_seq_if #(
  parameter int SS_W = 6
);
  logic            en;
  logic            clr_ok;
  logic            loop_en;
  logic [SS_W-1:0] ss_code;
  logic            ss_done;
  logic            fault;
  logic            lockout;
  logic [1:0]      retry_cnt;

  modport master (
    output en, clr_ok,
    input  loop_en, ss_code, ss_done, fault, lockout, retry_cnt
  );

  modport slave (
    input  en, clr_ok,
    output loop_en, ss_code, ss_done, fault, lockout, retry_cnt
  );
endinterface

// File: rtl/loop_qual_seq.sv
// loop_qual_seq - debounces the fault-NOR flag, soft-starts the loop with a
// ramp code, regulates, and on a filtered fault shuts down and retries after
// a delay, locking out after MAX_RETRY failed attempts.
// Ports:
//   CELCLK          clock
//   CELRST          synchronous active-high reset
//   CELV/CELG/SUB   supply, ground, substrate (no logic function)
//   lq              control/status bundle (slave side)
//
// state | meaning
// IDLE  | disabled, everything cleared
// QUAL  | waiting for FILT_CNT consecutive clr_ok=1 samples
// RAMP  | loop enabled, ss_code stepping every SS_STEP_DIV clocks
// REG   | ramp complete, regulating at full code
// FAULT | one-cycle shutdown, retry bookkeeping
// WAIT  | retry delay of RETRY_DLY clocks, clr_ok ignored
// LOCK  | retries exhausted, held until en drops
module loop_qual_seq #(
  parameter int FILT_CNT    = 8,
  parameter int SS_W        = 6,
  parameter int SS_STEP_DIV = 4,
  parameter int RETRY_DLY   = 200,
  parameter int MAX_RETRY   = 3
) (
  input  logic             CELCLK,
  input  logic             CELRST,
  input  logic             CELV,
  input  logic             CELG,
  input  logic             SUB,
  loop_qual_seq_if.slave   lq
);

  localparam int DIV_W = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    QUAL  = 3'd1,
    RAMP  = 3'd2,
    REG   = 3'd3,
    FAULT = 3'd4,
    WAIT  = 3'd5,
    LOCK  = 3'd6
  } state_t;

  state_t          state_q, state_n;
  logic [3:0]      filt_q, filt_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic [SS_W-1:0] code_q, code_n;
  logic [1:0]      retry_q, retry_n;
  logic [7:0]      dly_q, dly_n;
  logic [SS_W-1:0] code_inc;
  logic            filt_flt;

  // Supply/substrate pins carry no logic.
  logic unused_pwr;
  assign unused_pwr = CELV ^ CELG ^ SUB;

  assign code_inc = code_q + 1'b1;
  // Filtered fault: the FILT_CNT-th consecutive low sample.
  assign filt_flt = !lq.clr_ok && (filt_q == 4'(FILT_CNT - 1));

  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      state_q <= IDLE;
      filt_q  <= '0;
      div_q   <= '0;
      code_q  <= '0;
      retry_q <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_n;
      filt_q  <= filt_n;
      div_q   <= div_n;
      code_q  <= code_n;
      retry_q <= retry_n;
      dly_q   <= dly_n;
    end
  end

  always_comb begin
    state_n = state_q;
    filt_n  = filt_q;
    div_n   = div_q;
    code_n  = code_q;
    retry_n = retry_q;
    dly_n   = '0;

    unique case (state_q)
      IDLE: begin
        div_n   = '0;
        code_n  = '0;
        retry_n = '0;
        if (lq.en) state_n = QUAL;
      end

      QUAL: begin
        div_n  = '0;
        code_n = '0;
        if (!lq.clr_ok)                          filt_n = '0;
        else if (filt_q == 4'(FILT_CNT - 1))     state_n = RAMP;
        else                                     filt_n = filt_q + 1'b1;
      end

      RAMP, REG: begin
        if (state_q == RAMP) begin
          if (div_q == DIV_W'(SS_STEP_DIV - 1)) begin
            div_n  = '0;
            code_n = code_inc;
            if (&code_inc) begin
              state_n = REG;
              retry_n = '0;
            end
          end else begin
            div_n = div_q + 1'b1;
          end
        end
        if (lq.clr_ok) filt_n = '0;
        else           filt_n = filt_q + 1'b1;
        // Fault exit wins over ramp completion on the same edge.
        if (filt_flt) begin
          state_n = FAULT;
          retry_n = retry_q;
          code_n  = '0;
          div_n   = '0;
        end
      end

      FAULT: begin
        code_n  = '0;
        div_n   = '0;
        retry_n = (retry_q == 2'd3) ? 2'd3 : retry_q + 1'b1;
        state_n = (retry_q == 2'(MAX_RETRY - 1)) ? LOCK : WAIT;
      end

      WAIT: begin
        if (dly_q == 8'(RETRY_DLY - 1)) state_n = QUAL;
        else                            dly_n   = dly_q + 1'b1;
      end

      LOCK: ;

      default: state_n = IDLE;
    endcase

    if (state_n != state_q) filt_n = '0;

    if (!lq.en) begin
      state_n = IDLE;
      filt_n  = '0;
      div_n   = '0;
      code_n  = '0;
      retry_n = '0;
      dly_n   = '0;
    end
  end

  assign lq.loop_en   = (state_q == RAMP) || (state_q == REG);
  assign lq.ss_done   = (state_q == REG);
  assign lq.fault     = (state_q == FAULT) || (state_q == WAIT) || (state_q == LOCK);
  assign lq.lockout   = (state_q == LOCK);
  assign lq.ss_code   = lq.loop_en ? code_q : '0;
  assign lq.retry_cnt = retry_q;

endmodule
